// File: rtl/shiftreg_rx.sv
// Receive side of the serial shift-register configuration link: deserialises dynamic
// and static frames MSB first and commits them only when the bit count is exact.
module shiftreg_rx #(
    parameter int SIZESRSTAT    = 88,
    parameter int SIZESRDYN     = 16,
    parameter int CNTW          = 8,
    parameter int LATCH_TIMEOUT = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sel_dyn,
    input  logic                  sel_stat,
    input  logic                  en_fin,
    input  logic                  serial_in,
    input  logic                  err_clr,
    output logic [SIZESRDYN-1:0]  dyn_q,
    output logic [SIZESRSTAT-1:0] stat_q,
    output logic                  dyn_valid,
    output logic                  stat_valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int TW = $clog2(LATCH_TIMEOUT + 1);
    localparam logic [CNTW-1:0] DYN_LEN  = CNTW'(SIZESRDYN);
    localparam logic [CNTW-1:0] STAT_LEN = CNTW'(SIZESRSTAT);
    localparam logic [TW-1:0]   TMO_LAST = TW'(LATCH_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_DYN, WAIT_LATCH, SHIFT_STAT} state_t;

    state_t                  state_q;
    logic [SIZESRDYN-1:0]    dyn_sh_q;
    logic [SIZESRDYN-1:0]    dyn_word_q;
    logic [SIZESRSTAT-1:0]   stat_sh_q;
    logic [SIZESRSTAT-1:0]   stat_word_q;
    logic [CNTW-1:0]         cnt_q;
    logic [TW-1:0]           tmo_q;
    logic                    dyn_valid_q;
    logic                    stat_valid_q;
    logic                    frame_err_q;

    logic dshift, sshift, strobe, illegal;

    assign dshift  = sel_dyn & en_fin & ~sel_stat;
    assign sshift  = sel_stat & en_fin & ~sel_dyn;
    assign strobe  = sel_stat & ~en_fin & ~sel_dyn;
    assign illegal = sel_dyn & sel_stat;

    function automatic logic [CNTW-1:0] cnt_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            dyn_sh_q     <= '0;
            dyn_word_q   <= '0;
            stat_sh_q    <= '0;
            stat_word_q  <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            dyn_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            dyn_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            // Any later set in this block overrides the clear on the same edge.
            if (err_clr)
                frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (illegal) begin
                        frame_err_q <= 1'b1;
                    end else if (dshift) begin
                        dyn_sh_q <= SIZESRDYN'(serial_in);
                        cnt_q    <= CNTW'(1);
                        state_q  <= SHIFT_DYN;
                    end else if (sshift) begin
                        stat_sh_q <= SIZESRSTAT'(serial_in);
                        cnt_q     <= CNTW'(1);
                        state_q   <= SHIFT_STAT;
                    end
                end

                SHIFT_DYN: begin
                    if (illegal) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (dshift) begin
                        dyn_sh_q <= {dyn_sh_q[SIZESRDYN-2:0], serial_in};
                        cnt_q    <= cnt_inc(cnt_q);
                        if (cnt_q >= DYN_LEN)
                            frame_err_q <= 1'b1;
                    end else if (strobe) begin
                        if (cnt_q == DYN_LEN) begin
                            dyn_word_q  <= dyn_sh_q;
                            dyn_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (!en_fin) begin
                        tmo_q   <= '0;
                        state_q <= WAIT_LATCH;
                    end else begin
                        // en_fin without sel_dyn mid dynamic frame: abandon it
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                WAIT_LATCH: begin
                    if (illegal) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (strobe) begin
                        if (cnt_q == DYN_LEN) begin
                            dyn_word_q  <= dyn_sh_q;
                            dyn_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (dshift) begin
                        frame_err_q <= 1'b1;
                        dyn_sh_q    <= SIZESRDYN'(serial_in);
                        cnt_q       <= CNTW'(1);
                        state_q     <= SHIFT_DYN;
                    end else if (tmo_q == TMO_LAST) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                SHIFT_STAT: begin
                    if (illegal) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (sshift) begin
                        stat_sh_q <= {stat_sh_q[SIZESRSTAT-2:0], serial_in};
                        cnt_q     <= cnt_inc(cnt_q);
                        if (cnt_q >= STAT_LEN)
                            frame_err_q <= 1'b1;
                    end else if (!en_fin) begin
                        if (cnt_q == STAT_LEN) begin
                            stat_word_q  <= stat_sh_q;
                            stat_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign dyn_q      = dyn_word_q;
    assign stat_q     = stat_word_q;
    assign dyn_valid  = dyn_valid_q;
    assign stat_valid = stat_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shiftreg_rx.sv
// Directed plus randomized frame-level test of shiftreg_rx against a transaction model:
// a frame commits only if exactly the nominal number of bits was sent and latched in time.
module tb_shiftreg_rx;
    localparam int NS = 88;
    localparam int ND = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          sel_dyn;
    logic          sel_stat;
    logic          en_fin;
    logic          serial_in;
    logic          err_clr;
    logic [ND-1:0] dyn_q;
    logic [NS-1:0] stat_q;
    logic          dyn_valid;
    logic          stat_valid;
    logic          frame_err;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [ND-1:0] exp_dyn;
    logic [NS-1:0] exp_stat;
    logic          exp_err;

    always #5 CLK = ~CLK;

    shiftreg_rx #(
        .SIZESRSTAT   (NS),
        .SIZESRDYN    (ND),
        .CNTW         (8),
        .LATCH_TIMEOUT(32)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .sel_dyn    (sel_dyn),
        .sel_stat   (sel_stat),
        .en_fin     (en_fin),
        .serial_in  (serial_in),
        .err_clr    (err_clr),
        .dyn_q      (dyn_q),
        .stat_q     (stat_q),
        .dyn_valid  (dyn_valid),
        .stat_valid (stat_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; returns on the following falling edge.
    task automatic cyc(input logic sd, input logic ss, input logic en, input logic si);
        sel_dyn   = sd;
        sel_stat  = ss;
        en_fin    = en;
        serial_in = si;
        @(negedge CLK);
    endtask

    task automatic send_dyn(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--)
            cyc(1'b1, 1'b0, 1'b1, w[i]);
    endtask

    task automatic send_stat(input logic [95:0] w, input int n);
        for (int i = n - 1; i >= 0; i--)
            cyc(1'b0, 1'b1, 1'b1, w[i]);
    endtask

    task automatic do_strobe();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_err(input string tag);
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check(tag, 128'(frame_err), 128'(exp_err));
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dyn_q"}, 128'(dyn_q), 128'(exp_dyn));
        check({tag, ".stat_q"}, 128'(stat_q), 128'(exp_stat));
        check({tag, ".frame_err"}, 128'(frame_err), 128'(exp_err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".dyn_q"}, 128'(dyn_q), 128'(0));
        check({tag, ".stat_q"}, 128'(stat_q), 128'(0));
        check({tag, ".dyn_valid"}, 128'(dyn_valid), 128'(0));
        check({tag, ".stat_valid"}, 128'(stat_valid), 128'(0));
        check({tag, ".frame_err"}, 128'(frame_err), 128'(0));
        check({tag, ".busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        int          n;
        int          gap;
        logic        ok;
        logic [31:0] w;
        logic [95:0] sw;

        RST = 1'b1; sel_dyn = 1'b0; sel_stat = 1'b0; en_fin = 1'b0;
        serial_in = 1'b0; err_clr = 1'b0;
        exp_dyn = '0; exp_stat = '0; exp_err = 1'b0;
        @(negedge CLK);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_zero("reset");
        RST = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal dynamic frame, then post-latch idle pattern
        send_dyn(32'h1234, 16);
        check("t1.busy", 128'(busy), 128'(1));
        do_strobe();
        exp_dyn = 16'h1234;
        check("t1.dyn_valid", 128'(dyn_valid), 128'(1));
        check_model("t1");
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check("t1.idle_valid", 128'(dyn_valid), 128'(0));
        end
        check("t1.idle_busy", 128'(busy), 128'(0));
        check_model("t1.idle");
        $display("txn dyn 16 bits word=1234 latched");

        // Short frame
        send_dyn(32'h0ABC, 15);
        do_strobe();
        exp_err = 1'b1;
        check("t2.dyn_valid", 128'(dyn_valid), 128'(0));
        check_model("t2");
        clear_err("t2.clr");
        $display("txn dyn 15 bits rejected");

        // Overrun: error appears on the 17th shift edge
        w = 32'h0001_5555;
        send_dyn(w >> 1, 16);
        check("t3.err_at16", 128'(frame_err), 128'(0));
        cyc(1'b1, 1'b0, 1'b1, w[0]);
        check("t3.err_at17", 128'(frame_err), 128'(1));
        do_strobe();
        exp_err = 1'b1;
        check("t3.dyn_valid", 128'(dyn_valid), 128'(0));
        check_model("t3");
        clear_err("t3.clr");
        $display("txn dyn 17 bits rejected");

        // Static frame
        sw = {8'h00, 88'h0123456789ABCDEF012345};
        send_stat(sw, 88);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_stat = sw[87:0];
        check("t4.stat_valid", 128'(stat_valid), 128'(1));
        check("t4.dyn_valid", 128'(dyn_valid), 128'(0));
        check_model("t4");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4.stat_valid_off", 128'(stat_valid), 128'(0));
        $display("txn stat 88 bits committed");

        // Latch timeout boundary
        send_dyn(32'hBEEF, 16);
        repeat (32) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5.busy_before", 128'(busy), 128'(1));
        check("t5.err_before", 128'(frame_err), 128'(0));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_err = 1'b1;
        check("t5.busy_after", 128'(busy), 128'(0));
        check("t5.err_after", 128'(frame_err), 128'(1));
        do_strobe();
        check("t5.dyn_valid", 128'(dyn_valid), 128'(0));
        check_model("t5");
        clear_err("t5.clr");
        $display("txn dyn 16 bits timed out");

        // New frame while waiting for the latch
        send_dyn(32'h1111, 16);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        w = 32'h5A5A;
        cyc(1'b1, 1'b0, 1'b1, w[15]);
        check("t6.err_restart", 128'(frame_err), 128'(1));
        check("t6.busy", 128'(busy), 128'(1));
        send_dyn(w, 15);
        do_strobe();
        exp_dyn = 16'h5A5A;
        exp_err = 1'b1;
        check("t6.dyn_valid", 128'(dyn_valid), 128'(1));
        check_model("t6");
        clear_err("t6.clr");
        $display("txn dyn restart word=5a5a latched");

        // Both selects high in IDLE
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        exp_err = 1'b1;
        check("t7.err", 128'(frame_err), 128'(1));
        check("t7.busy", 128'(busy), 128'(0));
        clear_err("t7.clr");
        $display("txn illegal select flagged");

        // Reset mid-frame
        send_dyn(32'hFFFF, 8);
        RST = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_zero("t8.rst");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        exp_dyn = '0; exp_stat = '0; exp_err = 1'b0;
        send_dyn(32'hA5A5, 16);
        do_strobe();
        exp_dyn = 16'hA5A5;
        check("t8.dyn_valid", 128'(dyn_valid), 128'(1));
        check_model("t8");
        $display("txn reset mid-frame then word=a5a5 latched");

        // Randomized frames
        for (int t = 0; t < 48; t++) begin
            if ($urandom_range(0, 3) == 0)
                clear_err("rnd.clr");
            if ($urandom_range(0, 3) == 3) begin
                sw[95:64] = $urandom;
                sw[63:32] = $urandom;
                sw[31:0]  = $urandom;
                n = ($urandom_range(0, 2) == 0) ? (87 + 2 * $urandom_range(0, 1)) : 88;
                send_stat(sw, n);
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                ok = (n == NS);
                if (ok) exp_stat = sw[87:0];
                else    exp_err = 1'b1;
                check("rnd.stat_valid", 128'(stat_valid), 128'(ok));
                check("rnd.stat_dv", 128'(dyn_valid), 128'(0));
                check_model("rnd.stat");
                $display("txn %0d stat n=%0d commit=%0d", t, n, ok);
            end else begin
                w = $urandom;
                case ($urandom_range(0, 5))
                    0:       n = 15;
                    1:       n = 17;
                    default: n = 16;
                endcase
                gap = $urandom_range(0, 4);
                send_dyn(w, n);
                repeat (gap) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
                do_strobe();
                ok = (n == ND);
                if (ok) exp_dyn = w[15:0];
                else    exp_err = 1'b1;
                check("rnd.dyn_valid", 128'(dyn_valid), 128'(ok));
                check("rnd.dyn_sv", 128'(stat_valid), 128'(0));
                check_model("rnd.dyn");
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                check("rnd.dyn_valid_off", 128'(dyn_valid), 128'(0));
                $display("txn %0d dyn n=%0d gap=%0d word=%h commit=%0d", t, n, gap, w[15:0], ok);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
